// File: rtl/decode_pkg.sv
// Shared constants for the decode stage and the controller that produces CtrlIn.
// Field indices here must track the controller's control-word layout.
package decode_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_NREGS       = 32;
  localparam int DEF_CTRL_W      = 24;
  localparam int DEF_STALL_CNT_W = 16;

  localparam int REG_ZERO = 0;

  localparam int MEMREAD_BIT  = 0;
  localparam int MEMWRITE_BIT = 1;
  localparam int REGWRITE_BIT = 2;
  localparam int ALUSRC_BIT   = 3;
  localparam int MEMTOREG_BIT = 4;
  localparam int BRANCH_BIT   = 5;

endpackage

// File: rtl/regfile_2w2r.sv
// Register file with two combinational read ports and two write ports (writeback, link).
// Reads see same-cycle writes; link beats writeback when both target the same index.
module regfile_2w2r #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int LINK_REG = NREGS - 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_resetN,
  input  logic [AW-1:0]     i_rdAddr1,
  input  logic [AW-1:0]     i_rdAddr2,
  output logic [DATA_W-1:0] o_rdData1,
  output logic [DATA_W-1:0] o_rdData2,
  input  logic              i_wbWrite,
  input  logic [AW-1:0]     i_wbReg,
  input  logic [DATA_W-1:0] i_wbData,
  input  logic              i_linkWrite,
  input  logic [DATA_W-1:0] i_linkData
);
  import decode_pkg::*;

  localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [DATA_W-1:0] r_regs [NREGS];

  logic w_wbEn;
  logic w_linkEn;

  assign w_wbEn   = i_wbWrite && (i_wbReg != ZERO_IDX);
  assign w_linkEn = i_linkWrite && (LINK_IDX != ZERO_IDX);

  // The link write is issued last so it overrides a writeback to the same index.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_wbEn)   r_regs[i_wbReg] <= i_wbData;
      if (w_linkEn) r_regs[LINK_IDX] <= i_linkData;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [AW-1:0] addr);
    if (addr == ZERO_IDX)                   return '0;
    else if (w_linkEn && addr == LINK_IDX)  return i_linkData;
    else if (w_wbEn && addr == i_wbReg)     return i_wbData;
    else                                    return r_regs[addr];
  endfunction

  assign o_rdData1 = readPort(i_rdAddr1);
  assign o_rdData2 = readPort(i_rdAddr2);

endmodule

// File: rtl/decode_stage_pipelined.sv
// Pipelined decode stage: register read, immediate/PC+4 generation, load-use
// hazard detection and a handshaked ID/EX register with flush and stall counter.
module decode_stage_pipelined #(
  parameter int DATA_W      = decode_pkg::DEF_DATA_W,
  parameter int NREGS       = decode_pkg::DEF_NREGS,
  parameter int CTRL_W      = decode_pkg::DEF_CTRL_W,
  parameter int MEMREAD_BIT = decode_pkg::MEMREAD_BIT,
  parameter int LINK_REG    = NREGS - 1,
  parameter int STALL_CNT_W = decode_pkg::DEF_STALL_CNT_W,
  localparam int REG_AW     = $clog2(NREGS)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [31:0]            Instruction,
  input  logic [DATA_W-1:0]      PCResult,
  input  logic [CTRL_W-1:0]      CtrlIn,
  input  logic                   UsesRt,
  input  logic                   ZeroExt,
  input  logic                   Flush,
  input  logic                   WbWrite,
  input  logic [REG_AW-1:0]      WbReg,
  input  logic [DATA_W-1:0]      WbData,
  input  logic                   LinkWrite,
  input  logic [DATA_W-1:0]      LinkData,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [DATA_W-1:0]      ReadData1,
  output logic [DATA_W-1:0]      ReadData2,
  output logic [DATA_W-1:0]      ImmExt,
  output logic [REG_AW-1:0]      Rs,
  output logic [REG_AW-1:0]      Rt,
  output logic [REG_AW-1:0]      Rd,
  output logic [DATA_W-1:0]      PCPlus4,
  output logic [CTRL_W-1:0]      CtrlOut,
  output logic [STALL_CNT_W-1:0] StallCount
);
  import decode_pkg::*;

  logic [4:0]             w_rsField, w_rtField, w_rdField;
  logic [REG_AW-1:0]      w_rs, w_rt, w_rd;
  logic [15:0]            w_imm;
  logic [DATA_W-1:0]      w_immExt, w_pcPlus4, w_rdData1, w_rdData2;
  logic                   w_advance, w_hazard;
  logic                   w_unusedOpcode;

  logic                   r_valid;
  logic [DATA_W-1:0]      r_readData1, r_readData2, r_immExt, r_pcPlus4;
  logic [REG_AW-1:0]      r_rs, r_rt, r_rd;
  logic [CTRL_W-1:0]      r_ctrl;
  logic [STALL_CNT_W-1:0] r_stallCount;

  assign w_rsField      = Instruction[25:21];
  assign w_rtField      = Instruction[20:16];
  assign w_rdField      = Instruction[15:11];
  assign w_rs           = REG_AW'(w_rsField);
  assign w_rt           = REG_AW'(w_rtField);
  assign w_rd           = REG_AW'(w_rdField);
  assign w_imm          = Instruction[15:0];
  assign w_unusedOpcode = ^Instruction[31:26];

  assign w_immExt  = ZeroExt ? {{(DATA_W-16){1'b0}}, w_imm}
                             : {{(DATA_W-16){w_imm[15]}}, w_imm};
  assign w_pcPlus4 = PCResult + DATA_W'(4);

  regfile_2w2r #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .LINK_REG (LINK_REG)
  ) u_regfile (
    .i_clk       (Clk),
    .i_resetN    (Reset),
    .i_rdAddr1   (w_rs),
    .i_rdAddr2   (w_rt),
    .o_rdData1   (w_rdData1),
    .o_rdData2   (w_rdData2),
    .i_wbWrite   (WbWrite),
    .i_wbReg     (WbReg),
    .i_wbData    (WbData),
    .i_linkWrite (LinkWrite),
    .i_linkData  (LinkData)
  );

  // A load sitting in ID/EX blocks a consumer of its destination for one cycle.
  assign w_advance = !r_valid || OutReady;
  assign w_hazard  = r_valid && r_ctrl[MEMREAD_BIT] && (r_rt != REG_AW'(REG_ZERO)) &&
                     ((r_rt == w_rs) || (UsesRt && (r_rt == w_rt)));
  assign InReady   = Flush || (w_advance && !w_hazard);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_valid      <= 1'b0;
      r_readData1  <= '0;
      r_readData2  <= '0;
      r_immExt     <= '0;
      r_pcPlus4    <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_ctrl       <= '0;
      r_stallCount <= '0;
    end else if (Flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
        if (r_stallCount != '1) r_stallCount <= r_stallCount + STALL_CNT_W'(1);
      end else if (InValid) begin
        r_valid     <= 1'b1;
        r_readData1 <= w_rdData1;
        r_readData2 <= w_rdData2;
        r_immExt    <= w_immExt;
        r_pcPlus4   <= w_pcPlus4;
        r_rs        <= w_rs;
        r_rt        <= w_rt;
        r_rd        <= w_rd;
        r_ctrl      <= CtrlIn;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign OutValid   = r_valid;
  assign ReadData1  = r_readData1;
  assign ReadData2  = r_readData2;
  assign ImmExt     = r_immExt;
  assign PCPlus4    = r_pcPlus4;
  assign Rs         = r_rs;
  assign Rt         = r_rt;
  assign Rd         = r_rd;
  assign CtrlOut    = r_ctrl;
  assign StallCount = r_stallCount;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined: a vector table for the datapath plus
// hand-written sequences for bypass, load-use, backpressure, flush, link and reset.
module tb_decode_stage_pipelined;

  logic        Clk = 1'b0;
  logic        Reset, InValid, UsesRt, ZeroExt, Flush, WbWrite, LinkWrite, OutReady;
  logic [31:0] Instruction, PCResult, WbData, LinkData;
  logic [23:0] CtrlIn;
  logic [4:0]  WbReg;

  logic        InReady, OutValid;
  logic [31:0] ReadData1, ReadData2, ImmExt, PCPlus4;
  logic [4:0]  Rs, Rt, Rd;
  logic [23:0] CtrlOut;
  logic [15:0] StallCount;

  logic        inReady2, outValid2;
  logic [31:0] readData1b, readData2b, immExt2, pcPlus4b;
  logic [4:0]  rs2, rt2, rd2;
  logic [23:0] ctrlOut2;
  logic [1:0]  stallCount2;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  decode_stage_pipelined dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Instruction(Instruction), .PCResult(PCResult), .CtrlIn(CtrlIn),
    .UsesRt(UsesRt), .ZeroExt(ZeroExt), .Flush(Flush),
    .WbWrite(WbWrite), .WbReg(WbReg), .WbData(WbData),
    .LinkWrite(LinkWrite), .LinkData(LinkData),
    .OutValid(OutValid), .OutReady(OutReady),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ImmExt(ImmExt),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .PCPlus4(PCPlus4), .CtrlOut(CtrlOut),
    .StallCount(StallCount)
  );

  // Narrow stall counter instance, driven identically, to exercise saturation.
  decode_stage_pipelined #(.STALL_CNT_W(2)) dutSat (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(inReady2),
    .Instruction(Instruction), .PCResult(PCResult), .CtrlIn(CtrlIn),
    .UsesRt(UsesRt), .ZeroExt(ZeroExt), .Flush(Flush),
    .WbWrite(WbWrite), .WbReg(WbReg), .WbData(WbData),
    .LinkWrite(LinkWrite), .LinkData(LinkData),
    .OutValid(outValid2), .OutReady(OutReady),
    .ReadData1(readData1b), .ReadData2(readData2b), .ImmExt(immExt2),
    .Rs(rs2), .Rt(rt2), .Rd(rd2), .PCPlus4(pcPlus4b), .CtrlOut(ctrlOut2),
    .StallCount(stallCount2)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [23:0] ctrl;
    logic        zeroExt;
    logic [31:0] expImm;
    logic [31:0] expPc4;
    logic [4:0]  expRs, expRt, expRd;
  } vec_t;

  vec_t vecs [0:4];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [23:0] ctrl, input logic usesRt,
                               input logic zeroExt);
    InValid     = 1'b1;
    Instruction = instr;
    PCResult    = pc;
    CtrlIn      = ctrl;
    UsesRt      = usesRt;
    ZeroExt     = zeroExt;
  endtask

  task automatic goIdle();
    InValid     = 1'b0;
    Instruction = 32'h0;
    UsesRt      = 1'b0;
    CtrlIn      = 24'h0;
  endtask

  // lw $7,0($1) followed by add $8,$7,$0; ends with the add issued in ID/EX.
  task automatic loadUsePair();
    applyStimulus(32'h8C270000, 32'h200, 24'h000001, 1'b1, 1'b0);
    tick();
    applyStimulus(32'h00E04020, 32'h204, 24'h000000, 1'b1, 1'b0);
    #1 checkOutput("hazardInReady", InReady, 0);
    tick();
    checkOutput("bubbleValid", OutValid, 0);
    tick();
    checkOutput("addIssuedValid", OutValid, 1);
    checkOutput("addIssuedRd", Rd, 8);
  endtask

  initial begin
    vecs[0] = '{32'h2001FFFB, 32'h00000100, 24'hABCDE0, 1'b0, 32'hFFFFFFFB, 32'h00000104, 5'd0, 5'd1, 5'd31};
    vecs[1] = '{32'h34228001, 32'hFFFFFFFC, 24'h123456, 1'b1, 32'h00008001, 32'h00000000, 5'd1, 5'd2, 5'd16};
    vecs[2] = '{32'h34228001, 32'h00000000, 24'h000002, 1'b0, 32'hFFFF8001, 32'h00000004, 5'd1, 5'd2, 5'd16};
    vecs[3] = '{32'h00851820, 32'h00001000, 24'h00FF00, 1'b0, 32'h00001820, 32'h00001004, 5'd4, 5'd5, 5'd3};
    vecs[4] = '{32'h03FFF800, 32'h7FFFFFFC, 24'hFFFFFE, 1'b0, 32'hFFFFF800, 32'h80000000, 5'd31, 5'd31, 5'd31};

    Reset = 1'b0; OutReady = 1'b1; Flush = 1'b0; ZeroExt = 1'b0; PCResult = 32'h0;
    WbWrite = 1'b0; WbReg = 5'd0; WbData = 32'h0; LinkWrite = 1'b0; LinkData = 32'h0;
    goIdle();
    tick();
    tick();
    checkOutput("resetValid", OutValid, 0);
    checkOutput("resetPcPlus4", PCPlus4, 0);
    checkOutput("resetStall", StallCount, 0);
    Reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].pc, vecs[i].ctrl, 1'b1, vecs[i].zeroExt);
      #1 checkOutput("vecInReady", InReady, 1);
      tick();
      checkOutput("vecValid", OutValid, 1);
      checkOutput("vecImm", ImmExt, vecs[i].expImm);
      checkOutput("vecPcPlus4", PCPlus4, vecs[i].expPc4);
      checkOutput("vecCtrl", CtrlOut, vecs[i].ctrl);
      checkOutput("vecRs", Rs, vecs[i].expRs);
      checkOutput("vecRt", Rt, vecs[i].expRt);
      checkOutput("vecRd", Rd, vecs[i].expRd);
      checkOutput("vecRead1", ReadData1, 0);
    end

    // Writeback bypass and register zero.
    applyStimulus(32'h00A03020, 32'h300, 24'h0, 1'b1, 1'b0);
    WbWrite = 1'b1; WbReg = 5'd5; WbData = 32'hDEADBEEF;
    tick();
    checkOutput("bypassRead1", ReadData1, 32'hDEADBEEF);
    checkOutput("bypassRead2", ReadData2, 0);
    WbWrite = 1'b0;
    tick();
    checkOutput("storedRead1", ReadData1, 32'hDEADBEEF);
    applyStimulus(32'h00000020, 32'h304, 24'h0, 1'b1, 1'b0);
    WbWrite = 1'b1; WbReg = 5'd0; WbData = 32'h00001234;
    tick();
    checkOutput("zeroBypass", ReadData1, 0);
    WbWrite = 1'b0;
    tick();
    checkOutput("zeroStored", ReadData1, 0);

    // Load-use stall, then the same pair with rt not used as a source.
    loadUsePair();
    checkOutput("stallOnce", StallCount, 1);
    checkOutput("addIssuedRs", Rs, 7);
    applyStimulus(32'h8C270000, 32'h208, 24'h000001, 1'b1, 1'b0);
    tick();
    applyStimulus(32'h00074820, 32'h20C, 24'h000000, 1'b0, 1'b0);
    #1 checkOutput("noHazardInReady", InReady, 1);
    tick();
    checkOutput("noHazardValid", OutValid, 1);
    checkOutput("noHazardRd", Rd, 9);
    checkOutput("noHazardStall", StallCount, 1);

    // Backpressure: ID/EX holds the rd=9 instruction for three cycles.
    OutReady = 1'b0;
    applyStimulus(32'h00851820, 32'h00001000, 24'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 checkOutput("holdInReady", InReady, 0);
      tick();
      checkOutput("holdValid", OutValid, 1);
      checkOutput("holdRd", Rd, 9);
      checkOutput("holdPcPlus4", PCPlus4, 32'h210);
    end
    OutReady = 1'b1;
    #1 checkOutput("releaseInReady", InReady, 1);
    tick();
    checkOutput("releaseRd", Rd, 3);
    checkOutput("releasePcPlus4", PCPlus4, 32'h1004);

    // Flush wins over backpressure.
    OutReady = 1'b0;
    Flush    = 1'b1;
    #1 checkOutput("flushInReady", InReady, 1);
    tick();
    checkOutput("flushValid", OutValid, 0);
    checkOutput("flushStall", StallCount, 1);
    Flush    = 1'b0;
    OutReady = 1'b1;

    // Link and writeback to register 31 in the same cycle.
    applyStimulus(32'h03FFF800, 32'h400, 24'h0, 1'b1, 1'b0);
    LinkWrite = 1'b1; LinkData = 32'h00000400;
    WbWrite = 1'b1; WbReg = 5'd31; WbData = 32'h00000123;
    tick();
    checkOutput("linkBypass1", ReadData1, 32'h400);
    checkOutput("linkBypass2", ReadData2, 32'h400);
    LinkWrite = 1'b0; WbWrite = 1'b0;
    tick();
    checkOutput("linkStored", ReadData1, 32'h400);

    // Five more load-use hazards; the 2-bit counter saturates at 3.
    for (int h = 0; h < 5; h++) begin
      loadUsePair();
      if (h == 1) checkOutput("satEarly", stallCount2, 3);
    end
    checkOutput("stallWide", StallCount, 6);
    checkOutput("stallSat", stallCount2, 3);

    // Reset mid-stream with a valid instruction and a pending write.
    applyStimulus(32'h00851820, 32'h500, 24'hABCDEF, 1'b1, 1'b0);
    WbWrite = 1'b1; WbReg = 5'd5; WbData = 32'h00000055;
    Reset = 1'b0;
    tick();
    checkOutput("midResetValid", OutValid, 0);
    checkOutput("midResetImm", ImmExt, 0);
    checkOutput("midResetRead1", ReadData1, 0);
    checkOutput("midResetPc", PCPlus4, 0);
    checkOutput("midResetCtrl", CtrlOut, 0);
    checkOutput("midResetRd", Rd, 0);
    checkOutput("midResetStall", StallCount, 0);
    checkOutput("midResetStallSat", stallCount2, 0);
    Reset = 1'b1; WbWrite = 1'b0;
    applyStimulus(32'h00BF0020, 32'h600, 24'h0, 1'b1, 1'b0);
    tick();
    checkOutput("clearedReg5", ReadData1, 0);
    checkOutput("clearedReg31", ReadData2, 0);
    checkOutput("postResetValid", OutValid, 1);

    goIdle();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Parametrised, pipelined successor of the single-cycle decode stage.
- Contains:
  - the register file, with two write ports: writeback and jump-and-link;
  - immediate extension and PC+4 generation;
  - load-use hazard detection;
  - a registered ID/EX output stage with valid/ready handshake, flush, and a saturating stall counter.
- Sits between the fetch stage and execute. Control decode stays in the existing controller, whose control word passes through as CtrlIn.

Parameters:
- DATA_W, 32, register/PC/immediate datapath width; must be >= 32.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- REG_AW, $clog2(NREGS), register index width (derived).
- CTRL_W, 24, width of the controller word carried through.
- MEMREAD_BIT, 0, index of MemRead within CtrlIn.
- LINK_REG, NREGS-1, register written by the link port.
- STALL_CNT_W, 16, stall counter width.

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-low reset
- InValid  in  1  fetch presents an instruction
- InReady  out  1  instruction accepted this cycle (combinational)
- Instruction  in  32  fetched instruction
- PCResult  in  DATA_W  PC of the instruction
- CtrlIn  in  CTRL_W  controller outputs for Instruction
- UsesRt  in  1  instruction reads Instruction[20:16] as a source
- ZeroExt  in  1  zero-extend rather than sign-extend the immediate
- Flush  in  1  squash the stage (branch/jump taken)
- WbWrite  in  1  writeback port enable
- WbReg  in  REG_AW  writeback register index
- WbData  in  DATA_W  writeback data
- LinkWrite  in  1  link port enable; target is LINK_REG
- LinkData  in  DATA_W  return address
- OutValid  out  1  ID/EX register holds a real instruction
- OutReady  in  1  execute accepts this cycle
- ReadData1, ReadData2  out  DATA_W  registered operands (rs, rt)
- ImmExt  out  DATA_W  registered extended immediate
- Rs, Rt, Rd  out  REG_AW  registered register fields, low REG_AW bits of [25:21], [20:16], [15:11]
- PCPlus4  out  DATA_W  registered PCResult+4, modulo 2^DATA_W
- CtrlOut  out  CTRL_W  registered CtrlIn
- StallCount  out  STALL_CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (Reset=0 at a rising edge):
  - all output registers, StallCount and every register-file entry go to 0; OutValid=0;
  - any in-flight instruction is dropped; the write ports are ignored in that cycle.
- Register file:
  - reads are combinational; register 0 always reads 0, and writes to it are ignored;
  - write-first bypass: a read of an index being written this cycle returns the written data;
  - link and writeback to the same index in the same cycle: LinkData wins; otherwise both ports write.
- Advance = !OutValid || OutReady.
- Hazard (load-use) = OutValid && CtrlOut[MEMREAD_BIT] && Rt != 0 && (Rt == rs_in || (UsesRt && Rt == rt_in)).
- InReady = Flush || (Advance && !Hazard).
- Priority per rising edge:
  1. Flush: OutValid <= 0 even if OutReady=0; the incoming instruction is consumed and discarded; StallCount unchanged.
  2. Advance && Hazard: OutValid <= 0 (bubble); StallCount += 1, saturating at all-ones.
  3. Advance && InValid: load all output registers; OutValid <= 1.
  4. Advance && !InValid: OutValid <= 0; data registers hold.
  5. !Advance: all output registers hold (stable under backpressure).
- Latency: one cycle from acceptance to OutValid; throughput is one instruction per cycle when there is no hazard.
- A load-use pair yields exactly one bubble: after the bubble the load has left, so Hazard clears.
- ImmExt: Instruction[15:0], sign- or zero-extended to DATA_W per ZeroExt.

Decomposition:
- Shared package `decode_pkg`:
  - REG_ZERO constant;
  - default parameter constants;
  - the CTRL_W field index constants (MEMREAD_BIT etc.), shared with the controller.
- One sub-module, `regfile_2w2r`:
  - parameters DATA_W and NREGS, LINK_REG passed down;
  - two combinational read ports and two write ports, with the bypass and priority rules above.
- Hazard, handshake and pipeline register live in the top level.

Test Plan:
- Reset, then stream `addi $1,$0,-5` with ZeroExt=0 -> next cycle OutValid=1, ImmExt=0xFFFFFFFB, PCPlus4=PCResult+4; PCResult=0xFFFFFFFC gives PCPlus4=0.
- WbWrite reg 5 = 0xDEADBEEF in the same cycle an instruction reading rs=5 is accepted -> ReadData1=0xDEADBEEF (bypass); a write to reg 0 -> reads 0.
- `lw $7` followed by `add` with rs=7 -> InReady=0 for one cycle, one bubble with OutValid=0, StallCount=1, then the add is issued. Repeat with UsesRt=0 and rt=7 -> no stall.
- OutReady=0 for 3 cycles with OutValid=1 -> all outputs hold, InReady=0; release -> next instruction loads.
- Flush asserted with OutReady=0 and a valid input -> InReady=1, OutValid=0 next cycle, StallCount unchanged.
- LinkWrite=0x400 and WbWrite reg 31=0x123 in the same cycle -> reg 31 reads 0x400. STALL_CNT_W=2: five hazards -> StallCount=3. Reset mid-stream -> all outputs 0 next cycle.
